// File: rtl/mux10_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 10:1 mux datapath.
// Holds each grant for up to BURST accepted beats, then rotates with no idle bubble.
module mux10_rr_arbiter #(
  parameter int N     = 10,
  parameter int SEL_W = 4,
  parameter int BURST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             out_valid,
  output logic             out_last
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [3:0]       CNT_LAST = 4'(BURST - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);
  localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]       state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n;
  logic [3:0]       cnt, cnt_n;
  logic [N-1:0]     gnt_n;
  logic             vld_n, last_n;

  // Returns {found, index}; search wraps modulo N starting at p.
  function automatic logic [SEL_W:0] arb(input logic [N-1:0] r, input logic [SEL_W-1:0] p);
    logic             found;
    logic [SEL_W-1:0] w;
    int               t;
    found = 1'b0;
    w     = '0;
    for (int k = 0; k < N; k++) begin
      t = int'(p) + k;
      if (t >= N) t = t - N;
      if (!found && r[t]) begin
        found = 1'b1;
        w     = SEL_W'(t);
      end
    end
    return {found, w};
  endfunction

  logic [SEL_W-1:0] rel_ptr;
  logic [N-1:0]     rel_req;
  logic [SEL_W:0]   idle_win, rel_win;

  // Releasing index is masked unless it is the sole requester.
  always_comb begin
    rel_ptr = (sel == IDX_LAST) ? '0 : sel + 1'b1;
    rel_req = req & ~(ONE_HOT0 << sel);
    if (rel_req == '0) rel_req = req;
    idle_win = arb(req, ptr);
    rel_win  = arb(rel_req, rel_ptr);
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gnt_n   = gnt;
    vld_n   = out_valid;
    cnt_n   = cnt;
    if (state == IDLE) begin
      if (idle_win[SEL_W]) begin
        sel_n   = idle_win[SEL_W-1:0];
        gnt_n   = ONE_HOT0 << idle_win[SEL_W-1:0];
        vld_n   = 1'b1;
        cnt_n   = '0;
        state_n = GRANT;
      end else begin
        gnt_n = '0;
        vld_n = 1'b0;
      end
    end else if (out_ready && req[sel] && cnt < CNT_LAST) begin
      cnt_n = cnt + 4'd1;
    end else if (!out_ready && req[sel]) begin
      state_n = GRANT;
    end else begin
      ptr_n = rel_ptr;
      if (rel_win[SEL_W]) begin
        sel_n = rel_win[SEL_W-1:0];
        gnt_n = ONE_HOT0 << rel_win[SEL_W-1:0];
        vld_n = 1'b1;
        cnt_n = '0;
      end else begin
        gnt_n   = '0;
        vld_n   = 1'b0;
        cnt_n   = '0;
        state_n = IDLE;
      end
    end
    last_n = vld_n && (cnt_n == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      sel       <= sel_n;
      gnt       <= gnt_n;
      out_valid <= vld_n;
      out_last  <= last_n;
    end
  end

endmodule

// File: tb/tb_mux10_rr_arbiter.sv
// Directed bench for mux10_rr_arbiter: BURST=1 and BURST=2 instances share stimulus.
module tb_mux10_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  req;
  logic        out_ready;
  logic [3:0]  sel, sel2;
  logic [9:0]  gnt, gnt2;
  logic        out_valid, out_valid2, out_last, out_last2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mux10_rr_arbiter #(.N(10), .SEL_W(4), .BURST(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .out_valid(out_valid), .out_last(out_last));

  mux10_rr_arbiter #(.N(10), .SEL_W(4), .BURST(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel2), .gnt(gnt2), .out_valid(out_valid2), .out_last(out_last2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req       = 10'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    check("rst_sel",   32'(sel), 0);
    check("rst_gnt",   32'(gnt), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last",  32'(out_last), 0);
    req = '0;
    rst_n = 1'b1;
    tick();
    check("idle_valid", 32'(out_valid), 0);

    // single requester 3, re-granted every cycle
    req = 10'h008; out_ready = 1'b1;
    tick();
    check("single_sel",   32'(sel), 3);
    check("single_gnt",   32'(gnt), 32'h008);
    check("single_valid", 32'(out_valid), 1);
    check("single_last",  32'(out_last), 1);
    tick();
    check("single_regrant_sel",   32'(sel), 3);
    check("single_regrant_valid", 32'(out_valid), 1);

    // full rotation (BURST=1) and burst hold (BURST=2)
    do_reset();
    req = 10'h3FF; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("rot_sel",   32'(sel), k % 10);
      check("rot_gnt",   32'(gnt), 32'(1) << (k % 10));
      check("rot_valid", 32'(out_valid), 1);
      if (k < 6) begin
        check("burst_sel",  32'(sel2), k / 2);
        check("burst_last", 32'(out_last2), k % 2);
      end
    end

    // stall on requester 5, other req changes must not preempt
    do_reset();
    req = 10'h020; out_ready = 1'b0;
    tick();
    check("stall_grant", 32'(sel), 5);
    req = 10'h0A0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_sel",   32'(sel), 5);
      check("stall_valid", 32'(out_valid), 1);
      check("stall_gnt",   32'(gnt), 32'h020);
    end
    req = 10'h080;
    tick();
    check("abort_sel",   32'(sel), 7);
    check("abort_gnt",   32'(gnt), 32'h080);
    check("abort_valid", 32'(out_valid), 1);
    req = '0;
    tick();
    check("abort_idle_valid", 32'(out_valid), 0);
    check("abort_idle_gnt",   32'(gnt), 0);
    check("abort_idle_sel",   32'(sel), 7);
    check("abort_idle_last",  32'(out_last), 0);

    // fairness between 0 and 9, wrap modulo N
    do_reset();
    req = 10'h201; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fair_sel", 32'(sel), (k % 2 == 0) ? 0 : 9);
      check("fair_gnt", 32'(gnt), (k % 2 == 0) ? 32'h001 : 32'h200);
    end

    // asynchronous reset mid-grant, then ptr restarts at 0
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 0);
    check("async_gnt",   32'(gnt), 0);
    check("async_sel",   32'(sel), 0);
    check("async_last",  32'(out_last), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_sel",   32'(sel), 0);
    check("post_rst_valid", 32'(out_valid), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
